// File: rtl/multdiv_pkg.sv
// ----------------------------------------------------------------------------
// multdiv_pkg
//   Shared types and constants for the iterative multiply/divide unit.
//   - state_e      : control FSM states
//   - XLEN, ITERS  : operand width and iteration count (fixed at 32)
//   - CNT_W        : iteration counter width (counts 0..32, never wraps)
//   - INT_MIN      : most negative 32-bit value (divide-overflow case)
//   - BOOTH_*      : radix-2 Booth recode of {multiplier[0], q-1}
//   - abs32        : two's-complement magnitude helper
// ----------------------------------------------------------------------------
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int XLEN  = 32;
    localparam int ITERS = XLEN;
    localparam int CNT_W = 6;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS);
    localparam logic [XLEN-1:0]  INT_MIN  = 32'h8000_0000;

    // {multiplier[0], q-1} -> action on the accumulator
    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;

    // |v|; abs32(INT_MIN) yields 0x80000000, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] abs32(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/multdiv_addsub33.sv
// ----------------------------------------------------------------------------
// multdiv_addsub33
//   33-bit adder/subtractor shared by the Booth multiply step and the
//   restoring-division trial subtract.
//   Ports:
//     a   in  33  first operand
//     b   in  33  second operand
//     sub in  1   0: sum = a + b, 1: sum = a - b
//     sum out 33  result, modulo 2^33
// ----------------------------------------------------------------------------
module multdiv_addsub33 (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] sum
);

    // Subtraction as a + ~b + 1 so a single carry chain serves both modes.
    assign sum = a + (b ^ {33{sub}}) + {32'd0, sub};

endmodule

// File: rtl/multdiv_unit.sv
// ----------------------------------------------------------------------------
// multdiv_unit
//   Iterative signed 32-bit multiply / divide unit. A one-cycle ctrl_MULT or
//   ctrl_DIV pulse starts an operation; one bit is processed per clock and
//   data_resultRDY pulses for one cycle when the result is registered.
//   Multiply: radix-2 Booth on a 65-bit {acc, multiplier, q-1} register.
//   Divide  : restoring division on |A| / |B|, sign fixed up at the end.
//   A start pulse in any state aborts the current operation and restarts.
//
//   Ports:
//     clock          in   1   rising-edge clock
//     reset_n        in   1   asynchronous active-low reset
//     data_operandA  in   32  multiplicand / dividend (start cycle only)
//     data_operandB  in   32  multiplier / divisor (start cycle only)
//     ctrl_MULT      in   1   start multiply (wins over ctrl_DIV)
//     ctrl_DIV       in   1   start divide
//     data_result    out  32  last completed result
//     data_exception out  1   error flag, valid while data_resultRDY=1
//     data_resultRDY out  1   one-cycle completion pulse
//     busy           out  1   operation in flight (MUL, DIV or DONE)
//     dbg_state      out  2   current FSM state (state_e encoding)
//
//   Build option: MULTDIV_EARLY_OUT_EN -- a multiply with a zero operand or a
//   divide by zero skips the iterations and completes on the first edge after
//   the start edge. Without it every operation takes 33 cycles.
// ----------------------------------------------------------------------------
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    if (WIDTH != XLEN) begin : g_width_check
        $error("multdiv_unit: only WIDTH=32 is supported");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    acc_q, acc_d;      // Booth accumulator / division remainder
    logic [XLEN-1:0]    mq_q, mq_d;        // multiplier -> product low / dividend -> quotient
    logic               qm1_q, qm1_d;      // Booth q-1 bit
    logic [XLEN-1:0]    mcand_q, mcand_d;  // multiplicand / divisor magnitude
    logic               neg_q, neg_d;      // quotient must be negated
    logic               divz_q, divz_d;    // divide by zero
    logic               ovf_q, ovf_d;      // INT_MIN / -1
    logic [XLEN-1:0]    res_q, res_d;
    logic               exc_q, exc_d;
`ifdef MULTDIV_EARLY_OUT_EN
    logic               early_q, early_d;  // result known without iterating
`endif

    logic               start;
    logic               iter_done;
    logic [1:0]         booth_code;
    logic [32:0]        div_shift;
    logic [32:0]        add_a, add_b, add_sum;
    logic               add_sub;
    logic [XLEN-1:0]    mul_res, div_res;
    logic               mul_exc, div_exc;

    assign start      = ctrl_MULT | ctrl_DIV;
    assign booth_code = {mq_q[0], qm1_q};
    // Remainder shifted left with the next dividend bit brought in.
    assign div_shift  = {acc_q, mq_q[XLEN-1]};

`ifdef MULTDIV_EARLY_OUT_EN
    assign iter_done = (cnt_q == CNT_LAST) || early_q;
`else
    assign iter_done = (cnt_q == CNT_LAST);
`endif

    // ------------------------------------------------------------------
    // Shared adder operand selection
    // ------------------------------------------------------------------
    always_comb begin
        add_a   = {acc_q[XLEN-1], acc_q};
        add_b   = {mcand_q[XLEN-1], mcand_q};
        add_sub = 1'b0;
        if (state_q == DIV) begin
            add_a   = div_shift;
            add_b   = {1'b0, mcand_q};
            add_sub = 1'b1;
        end else begin
            case (booth_code)
                BOOTH_ADD:              add_sub = 1'b0;
                BOOTH_SUB:              add_sub = 1'b1;
                BOOTH_NOP0, BOOTH_NOP1: add_b   = '0;
                default:                add_b   = '0;
            endcase
        end
    end

    multdiv_addsub33 u_addsub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .sum (add_sum)
    );

    // ------------------------------------------------------------------
    // Result formation from the final iteration registers
    // ------------------------------------------------------------------
    always_comb begin
        mul_res = mq_q;
        // Product overflows 32 bits when the high word is not all copies of bit 31.
        mul_exc = (acc_q != {XLEN{mq_q[XLEN-1]}});
`ifdef MULTDIV_EARLY_OUT_EN
        if (early_q) begin
            mul_res = '0;
            mul_exc = 1'b0;
        end
`endif
    end

    always_comb begin
        div_exc = divz_q | ovf_q;
        if (divz_q) begin
            div_res = '0;
        end else if (ovf_q) begin
            div_res = INT_MIN;
        end else if (neg_q) begin
            div_res = ~mq_q + 32'd1;
        end else begin
            div_res = mq_q;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        qm1_d   = qm1_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        divz_d  = divz_q;
        ovf_d   = ovf_q;
        res_d   = res_q;
        exc_d   = exc_q;
`ifdef MULTDIV_EARLY_OUT_EN
        early_d = early_q;
`endif

        case (state_q)
            MUL: begin
                if (iter_done) begin
                    state_d = DONE;
                    res_d   = mul_res;
                    exc_d   = mul_exc;
                end else begin
                    // Add/sub then arithmetic shift right of {acc, mq, q-1}.
                    acc_d = add_sum[32:1];
                    mq_d  = {add_sum[0], mq_q[XLEN-1:1]};
                    qm1_d = mq_q[0];
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DIV: begin
                if (iter_done) begin
                    state_d = DONE;
                    res_d   = div_res;
                    exc_d   = div_exc;
                end else begin
                    // Trial subtract; a non-negative difference sets the quotient bit.
                    if (!add_sum[32]) begin
                        acc_d = add_sum[XLEN-1:0];
                        mq_d  = {mq_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[XLEN-1:0];
                        mq_d  = {mq_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A start pulse overrides everything above, including a completion
        // that would otherwise be registered this edge.
        if (start) begin
            cnt_d  = '0;
            acc_d  = '0;
            qm1_d  = 1'b0;
            res_d  = res_q;
            exc_d  = exc_q;
            if (ctrl_MULT) begin
                state_d = MUL;
                mcand_d = data_operandA;
                mq_d    = data_operandB;
                neg_d   = 1'b0;
                divz_d  = 1'b0;
                ovf_d   = 1'b0;
`ifdef MULTDIV_EARLY_OUT_EN
                early_d = (data_operandA == '0) || (data_operandB == '0);
`endif
            end else begin
                state_d = DIV;
                mcand_d = abs32(data_operandB);
                mq_d    = abs32(data_operandA);
                neg_d   = data_operandA[XLEN-1] ^ data_operandB[XLEN-1];
                divz_d  = (data_operandB == '0);
                ovf_d   = (data_operandA == INT_MIN) && (data_operandB == '1);
`ifdef MULTDIV_EARLY_OUT_EN
                early_d = (data_operandB == '0);
`endif
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            divz_q  <= 1'b0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
`ifdef MULTDIV_EARLY_OUT_EN
            early_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            qm1_q   <= qm1_d;
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            divz_q  <= divz_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
`ifdef MULTDIV_EARLY_OUT_EN
            early_q <= early_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q != IDLE);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// ----------------------------------------------------------------------------
// tb_multdiv_unit
//   Scoreboard bench for multdiv_unit. Each issued operation pushes its
//   expected result, exception and completion cycle (computed with 64-bit
//   integer arithmetic) into exp_q; a negedge monitor compares busy, RDY,
//   result and exception every cycle. Restarts drop the aborted entry and
//   resets flush the queue.
// ----------------------------------------------------------------------------
module tb_multdiv_unit;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;        // cycle in which RDY must be seen
        int          busy_from;  // first cycle in which busy must be seen
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    logic [1:0]  dbg_state;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          compared = 0;
    int          failed = 0;
    logic [31:0] last_res = '0;
    logic        mon_has, mon_busy, mon_rdy;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                 32'h7FFF_FFFF, 32'h0001_0000};

    multdiv_unit u_dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    // ------------------------------------------------------------------
    // Clock / cycle count
    // ------------------------------------------------------------------
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic void ref_model(input logic is_mul, input logic [31:0] a,
                                      input logic [31:0] b,
                                      output logic [31:0] r, output logic e);
        longint sa, sb, p, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mul) begin
            p = sa * sb;
            r = p[31:0];
            e = (p != longint'($signed(r)));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
            r = INT_MIN;
            e = 1'b1;
        end else begin
            q = sa / sb;  // truncates toward zero
            r = q[31:0];
            e = 1'b0;
        end
    endfunction

    // Edges from the start edge to the edge on which RDY rises.
    function automatic int latency(input logic is_mul, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef MULTDIV_EARLY_OUT_EN
        if (is_mul ? (a == 32'd0 || b == 32'd0) : (b == 32'd0)) return 1;
`endif
        return 33;
    endfunction

    // ------------------------------------------------------------------
    // Checking helpers and monitor
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            mon_has  = (exp_q.size() > 0);
            mon_busy = mon_has && (cyc >= exp_q[0].busy_from);
            mon_rdy  = mon_has && (exp_q[0].due == cyc);
            chk("busy", {31'd0, busy}, {31'd0, mon_busy});
            chk("rdy", {31'd0, data_resultRDY}, {31'd0, mon_rdy});
            if (mon_rdy) begin
                last_res = exp_q[0].res;
                chk("exception", {31'd0, data_exception}, {31'd0, exp_q[0].exc});
                void'(exp_q.pop_front());
            end else if (mon_has && exp_q[0].due < cyc) begin
                void'(exp_q.pop_front());
            end
            chk("result", data_result, last_res);
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (all entered and left 2 time units after a rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b);
        exp_t n;
        int   bf;
        bf = cyc + 1;
        // An operation not yet showing RDY is aborted by this start.
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) begin
            bf = exp_q[exp_q.size()-1].busy_from;
            void'(exp_q.pop_back());
        end
        ref_model(m, a, b, n.res, n.exc);
        n.due       = cyc + 1 + latency(m, a, b);
        n.busy_from = bf;
        exp_q.push_back(n);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        tick();
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0) begin
            compared++;
            failed++;
            $display("FAIL timeout at cycle %0d: got no RDY, expected RDY within %0d cycles",
                     cyc, bound);
            exp_q.delete();
        end
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        #1;
        chk("reset result", data_result, 32'd0);
        chk("reset exception", {31'd0, data_exception}, 32'd0);
        chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        last_res = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0, 1:    return corners[$urandom_range(0, 5)];
            2:       return 32'($urandom_range(0, 40)) - 32'd20;
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic        m;
        logic [31:0] a, b;

        tick();
        tick();
        reset_pulse();
        tick();

        // Multiply
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);           wait_done(60);
        issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);   wait_done(60);
        issue(1'b1, 1'b0, INT_MIN, 32'd1);                 wait_done(60);
        issue(1'b1, 1'b0, INT_MIN, INT_MIN);               wait_done(60);

        // Divide
        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);           wait_done(60);
        issue(1'b0, 1'b1, 32'd100, 32'd0);                 wait_done(60);
        issue(1'b0, 1'b1, INT_MIN, 32'hFFFF_FFFF);         wait_done(60);
        issue(1'b0, 1'b1, 32'd7, 32'hFFFF_FFF9);           wait_done(60);

        // Restart mid-multiply with a divide: only the divide completes
        issue(1'b1, 1'b0, 32'd5, 32'd6);
        repeat (9) tick();
        issue(1'b0, 1'b1, 32'd20, 32'd4);                  wait_done(60);

        // Both start strobes: multiply wins
        issue(1'b1, 1'b1, 32'd9, 32'hFFFF_FFFC);           wait_done(60);

        // Reset in the middle of an operation; no RDY may follow
        issue(1'b1, 1'b0, 32'd123, 32'd456);
        repeat (14) tick();
        reset_pulse();
        repeat (40) tick();
        issue(1'b0, 1'b1, 32'd1000, 32'hFFFF_FFF9);        wait_done(60);

        // Zero operand (early completion when the option is built in)
        issue(1'b1, 1'b0, 32'd0, 32'd9);                   wait_done(60);
        issue(1'b1, 1'b0, 32'd9, 32'd0);                   wait_done(60);

        // Randomized operations, with occasional restarts
        for (int i = 0; i < 24; i++) begin
            m = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            issue(m, ~m, a, b);
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(1, 31)) tick();
                m = 1'($urandom_range(0, 1));
                issue(m, ~m, pick(), pick());
            end
            wait_done(60);
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
